// File: rtl/cr_zigzag_rle_if.sv
// Block-in / symbol-out bundle between the Cr quantizer, the zigzag/RLE stage and the
// Cr Huffman encoder.
interface cr_zigzag_rle_if #(
  parameter int unsigned CW = 11,
  parameter int unsigned DW = 12
);
  logic                 enable;
  logic signed [CW-1:0] q [1:8][1:8];
  logic                 sym_valid;
  logic                 sym_ready;
  logic                 sym_dc;
  logic                 sym_eob;
  logic                 sym_zrl;
  logic [3:0]           sym_run;
  logic signed [DW-1:0] sym_value;
  logic                 sym_last;

  modport master (
    output enable, q, sym_ready,
    input  sym_valid, sym_dc, sym_eob, sym_zrl, sym_run, sym_value, sym_last
  );

  modport slave (
    input  enable, q, sym_ready,
    output sym_valid, sym_dc, sym_eob, sym_zrl, sym_run, sym_value, sym_last
  );
endinterface

// File: rtl/cr_zigzag_rle.sv
// Double-buffered zigzag scanner for quantized 8x8 Cr blocks; emits DC difference,
// AC (run, value), ZRL and EOB symbols under valid/ready backpressure.
module cr_zigzag_rle #(
  parameter int unsigned CW = 11,
  parameter int unsigned DW = 12
) (
  input  logic           clk,
  input  logic           rst,
  cr_zigzag_rle_if.slave zz,
  output logic           busy,
  output logic           drop_err
);

  typedef enum logic [1:0] {StIdle, StDc, StAc, StEob} state_e;

  // Row-major (0-based) position of each zigzag index k
  localparam logic [5:0] ZzPos [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [CW-1:0] q_flat [64];
  logic [CW-1:0] cap [64];
  logic [63:0]   cap_nz;
  logic [5:0]    cap_last;

  logic [CW-1:0] w_buf_q [64];
  logic [CW-1:0] w_buf_d [64];
  logic [CW-1:0] p_buf_q [64];
  logic [CW-1:0] p_buf_d [64];
  logic [5:0]    w_last_q, w_last_d, p_last_q, p_last_d;
  logic          w_valid_q, w_valid_d, p_valid_q, p_valid_d;
  logic          drop_err_q, drop_err_d;

  state_e        state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [3:0]    run_q, run_d;
  logic [DW-1:0] prev_dc_q, prev_dc_d;
  logic          release_w;
  state_e        next_blk;

  logic [CW-1:0] coef;
  logic [DW-1:0] ac_value, dc_sext;

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      assign q_flat[r*8+c] = zz.q[r+1][c+1];
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_zz
    assign cap[i]    = q_flat[ZzPos[i]];
    assign cap_nz[i] = (cap[i] != '0);
  end

  always_comb begin
    cap_last = '0;
    for (int i = 1; i < 64; i++) begin
      if (cap_nz[i]) cap_last = 6'(i);
    end
  end

  // Buffer management: P refills W on release; a fresh block goes wherever space opens
  always_comb begin
    w_buf_d    = w_buf_q;
    p_buf_d    = p_buf_q;
    w_last_d   = w_last_q;
    p_last_d   = p_last_q;
    w_valid_d  = w_valid_q;
    p_valid_d  = p_valid_q;
    drop_err_d = drop_err_q;
    if (release_w) begin
      if (p_valid_q) begin
        w_buf_d   = p_buf_q;
        w_last_d  = p_last_q;
        p_valid_d = zz.enable;
        if (zz.enable) begin
          p_buf_d  = cap;
          p_last_d = cap_last;
        end
      end else begin
        w_valid_d = zz.enable;
        if (zz.enable) begin
          w_buf_d  = cap;
          w_last_d = cap_last;
        end
      end
    end else if (zz.enable) begin
      if (!w_valid_q) begin
        w_valid_d = 1'b1;
        w_buf_d   = cap;
        w_last_d  = cap_last;
      end else if (!p_valid_q) begin
        p_valid_d = 1'b1;
        p_buf_d   = cap;
        p_last_d  = cap_last;
      end else begin
        drop_err_d = 1'b1;
      end
    end
  end

  assign coef     = w_buf_q[k_q];
  assign ac_value = {{(DW-CW){coef[CW-1]}}, coef};
  assign dc_sext  = {{(DW-CW){w_buf_q[0][CW-1]}}, w_buf_q[0]};
  assign next_blk = (p_valid_q || zz.enable) ? StDc : StIdle;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    run_d        = run_q;
    prev_dc_d    = prev_dc_q;
    release_w    = 1'b0;
    zz.sym_valid = 1'b0;
    zz.sym_dc    = 1'b0;
    zz.sym_eob   = 1'b0;
    zz.sym_zrl   = 1'b0;
    zz.sym_run   = '0;
    zz.sym_value = '0;
    zz.sym_last  = 1'b0;
    unique case (state_q)
      StIdle: if (w_valid_q) state_d = StDc;
      StDc: begin
        zz.sym_valid = 1'b1;
        zz.sym_dc    = 1'b1;
        zz.sym_value = dc_sext - prev_dc_q;
        if (zz.sym_ready) begin
          prev_dc_d = dc_sext;
          k_d       = 6'd1;
          run_d     = '0;
          state_d   = (w_last_q == '0) ? StEob : StAc;
        end
      end
      StAc: begin
        if (coef == '0) begin
          // Zeros before last_nz are absorbed silently until a ZRL is due
          if (run_q == 4'd15) begin
            zz.sym_valid = 1'b1;
            zz.sym_zrl   = 1'b1;
            zz.sym_run   = 4'd15;
            if (zz.sym_ready) begin
              run_d = '0;
              k_d   = k_q + 6'd1;
            end
          end else begin
            run_d = run_q + 4'd1;
            k_d   = k_q + 6'd1;
          end
        end else begin
          zz.sym_valid = 1'b1;
          zz.sym_run   = run_q;
          zz.sym_value = ac_value;
          zz.sym_last  = (k_q == 6'd63);
          if (zz.sym_ready) begin
            run_d = '0;
            k_d   = k_q + 6'd1;
            if (k_q == w_last_q) begin
              release_w = (k_q == 6'd63);
              state_d   = (k_q == 6'd63) ? next_blk : StEob;
            end
          end
        end
      end
      StEob: begin
        zz.sym_valid = 1'b1;
        zz.sym_eob   = 1'b1;
        zz.sym_last  = 1'b1;
        if (zz.sym_ready) begin
          release_w = 1'b1;
          state_d   = next_blk;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      run_q      <= '0;
      prev_dc_q  <= '0;
      w_valid_q  <= 1'b0;
      p_valid_q  <= 1'b0;
      w_last_q   <= '0;
      p_last_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      run_q      <= run_d;
      prev_dc_q  <= prev_dc_d;
      w_valid_q  <= w_valid_d;
      p_valid_q  <= p_valid_d;
      w_last_q   <= w_last_d;
      p_last_q   <= p_last_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Coefficient storage is qualified by the valid flags, so it needs no reset
  always_ff @(posedge clk) begin
    w_buf_q <= w_buf_d;
    p_buf_q <= p_buf_d;
  end

  assign busy     = w_valid_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_cr_zigzag_rle.sv
// Self-checking bench for cr_zigzag_rle: vector table, hand sequences and randomized
// blocks against a run-length reference model.
module tb_cr_zigzag_rle;

  typedef struct packed {
    logic        dc;
    logic        eob;
    logic        zrl;
    logic        last;
    logic [3:0]  run;
    logic [11:0] value;
  } sym_t;

  typedef struct {
    int q11;
    int k1;
    int v1;
    int k2;
    int v2;
    int nsym;
    int dc;
    bit eob_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic drop_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   blk [64];
  int   zz_pos [64];
  int   m_prev_dc;
  sym_t exp_q [$];
  sym_t got_q [$];
  vec_t vt [7];

  cr_zigzag_rle_if #(.CW(11), .DW(12)) zif ();

  cr_zigzag_rle #(.CW(11), .DW(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .zz       (zif),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic sym_t sample();
    sym_t s;
    s.dc    = zif.sym_dc;
    s.eob   = zif.sym_eob;
    s.zrl   = zif.sym_zrl;
    s.last  = zif.sym_last;
    s.run   = zif.sym_run;
    s.value = zif.sym_value;
    return s;
  endfunction

  // Reference: JPEG run-length coding of the zigzag sequence, DC coded as a difference
  function automatic void model_block();
    sym_t s;
    int   run;
    int   last_nz;
    int   v;
    s       = '0;
    s.dc    = 1'b1;
    s.value = 12'(blk[0] - m_prev_dc);
    exp_q.push_back(s);
    m_prev_dc = blk[0];
    last_nz = 0;
    for (int k = 1; k < 64; k++) if (blk[zz_pos[k]] != 0) last_nz = k;
    run = 0;
    for (int k = 1; k <= last_nz; k++) begin
      v = blk[zz_pos[k]];
      if (v == 0) begin
        run++;
      end else begin
        while (run > 15) begin
          s = '0; s.zrl = 1'b1; s.run = 4'd15;
          exp_q.push_back(s);
          run -= 16;
        end
        s = '0; s.run = 4'(run); s.value = 12'(v); s.last = (k == 63);
        exp_q.push_back(s);
        run = 0;
      end
    end
    if (last_nz < 63) begin
      s = '0; s.eob = 1'b1; s.last = 1'b1;
      exp_q.push_back(s);
    end
  endfunction

  task automatic clear_blk();
    for (int p = 0; p < 64; p++) blk[p] = 0;
  endtask

  task automatic pulse();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) zif.q[r+1][c+1] = 11'(blk[r*8+c]);
    zif.enable = 1'b1;
    @(negedge clk);
    zif.enable = 1'b0;
  endtask

  task automatic rand_block();
    int dens;
    clear_blk();
    case ($urandom_range(0, 3))
      0:       dens = 0;
      1:       dens = 4;
      2:       dens = 25;
      default: dens = 90;
    endcase
    blk[0] = int'($urandom_range(0, 2047)) - 1024;
    for (int k = 1; k < 64; k++)
      if (int'($urandom_range(0, 99)) < dens) blk[zz_pos[k]] = int'($urandom_range(0, 2047)) - 1024;
  endtask

  // Called at a negedge; collects symbols of nblk blocks, checking hold while stalled
  task automatic drain(input int nblk, input int pct);
    int   done = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    sym_t prev = '0;
    sym_t cur;
    while (done < nblk && cyc < 3000) begin
      cur = sample();
      if (stalled) begin
        vectors++;
        if (!zif.sym_valid || cur != prev) begin
          miscompares++;
          $display("FAIL stall_hold: got %h valid=%0b want %h valid=1", cur, zif.sym_valid, prev);
        end
      end
      zif.sym_ready = (int'($urandom_range(0, 99)) < pct);
      stalled = zif.sym_valid && !zif.sym_ready;
      if (zif.sym_valid && zif.sym_ready) begin
        got_q.push_back(cur);
        if (cur.last) done++;
      end
      prev = cur;
      cyc++;
      @(negedge clk);
    end
    zif.sym_ready = 1'b0;
    if (done < nblk) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d blocks want %0d", done, nblk);
    end
  endtask

  task automatic check_stream(input string name);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_len: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] != exp_q[i]) begin
        miscompares++;
        $display("FAIL %s sym%0d: got dc=%0b eob=%0b zrl=%0b last=%0b run=%0d val=%0d want dc=%0b eob=%0b zrl=%0b last=%0b run=%0d val=%0d",
                 name, i, got_q[i].dc, got_q[i].eob, got_q[i].zrl, got_q[i].last, got_q[i].run,
                 $signed(got_q[i].value), exp_q[i].dc, exp_q[i].eob, exp_q[i].zrl, exp_q[i].last,
                 exp_q[i].run, $signed(exp_q[i].value));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  int h_zrl [5] = '{1, 0, 1, 1, 0};
  int h_run [5] = '{15, 3, 15, 15, 10};
  int h_val [5] = '{0, -5, 0, 0, 7};
  int h_lst [5] = '{0, 0, 0, 0, 1};

  initial begin
    int idx;
    int c;
    int nb;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 1) begin
        for (int r = 0; r < 8; r++) begin
          c = s - r;
          if (c >= 0 && c < 8) begin zz_pos[idx] = r * 8 + c; idx++; end
        end
      end else begin
        for (int r = 7; r >= 0; r--) begin
          c = s - r;
          if (c >= 0 && c < 8) begin zz_pos[idx] = r * 8 + c; idx++; end
        end
      end
    end

    vt[0] = '{0,     -1, 0,    -1, 0, 2, 0,     1'b1};
    vt[1] = '{100,   -1, 0,    -1, 0, 2, 100,   1'b1};
    vt[2] = '{-20,   -1, 0,    -1, 0, 2, -120,  1'b1};
    vt[3] = '{0,     20, -5,   63, 7, 6, 20,    1'b0};
    vt[4] = '{5,      1, 3,    -1, 0, 3, 5,     1'b1};
    vt[5] = '{-1024, 63, 1023, -1, 0, 5, -1029, 1'b0};
    vt[6] = '{1023,  -1, 0,    -1, 0, 2, 2047,  1'b1};

    rst = 1'b1;
    zif.enable = 1'b0;
    zif.sym_ready = 1'b0;
    clear_blk();
    for (int r = 1; r <= 8; r++) for (int cc = 1; cc <= 8; cc++) zif.q[r][cc] = '0;
    repeat (3) @(negedge clk);
    chk("rst_sym", int'(sample()), 0);
    chk("rst_valid", zif.sym_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    rst = 1'b0;
    m_prev_dc = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_blk();
      blk[0] = vt[i].q11;
      if (vt[i].k1 >= 0) blk[zz_pos[vt[i].k1]] = vt[i].v1;
      if (vt[i].k2 >= 0) blk[zz_pos[vt[i].k2]] = vt[i].v2;
      pulse();
      model_block();
      chk("lat_busy", busy, 1);
      chk("lat_idle", zif.sym_valid, 0);
      @(negedge clk);
      chk("lat_dc", int'(zif.sym_valid & zif.sym_dc), 1);
      drain(1, 100);
      chk("busy_after_last", busy, 0);
      chk("vec_nsym", got_q.size(), vt[i].nsym);
      if (got_q.size() > 0) begin
        chk("vec_dc", int'($signed(got_q[0].value)), vt[i].dc);
        chk("vec_eob_last", int'(got_q[got_q.size()-1].eob), int'(vt[i].eob_last));
      end
      check_stream("vec");
    end

    // Sparse k=20 / k=63 block again, under random backpressure
    clear_blk();
    blk[zz_pos[20]] = -5;
    blk[zz_pos[63]] = 7;
    pulse();
    model_block();
    drain(1, 50);
    chk("hand_nsym", got_q.size(), 6);
    for (int i = 0; i < 5 && i + 1 < got_q.size(); i++) begin
      chk("hand_zrl", int'(got_q[i+1].zrl), h_zrl[i]);
      chk("hand_run", int'(got_q[i+1].run), h_run[i]);
      chk("hand_val", int'($signed(got_q[i+1].value)), h_val[i]);
      chk("hand_last", int'(got_q[i+1].last), h_lst[i]);
    end
    check_stream("stall");

    // Three back-to-back blocks with no consumer: third one must be dropped
    clear_blk(); blk[0] = 7; blk[zz_pos[5]] = -3;
    pulse(); model_block();
    clear_blk(); blk[0] = -9; blk[zz_pos[30]] = 100; blk[zz_pos[2]] = 1;
    pulse(); model_block();
    clear_blk(); blk[0] = 300; blk[zz_pos[9]] = 44;
    pulse();
    chk("drop_err_set", drop_err, 1);
    chk("drop_busy", busy, 1);
    drain(2, 100);
    check_stream("dbuf");
    chk("drop_err_sticky", drop_err, 1);

    // Reset in the middle of an AC scan
    clear_blk();
    for (int p = 0; p < 64; p++) blk[p] = p + 1;
    pulse();
    zif.sym_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    zif.sym_ready = 1'b0;
    @(negedge clk);
    chk("midrst_sym", int'(sample()), 0);
    chk("midrst_valid", zif.sym_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_drop", drop_err, 0);
    rst = 1'b0;
    m_prev_dc = 0;
    @(negedge clk);
    clear_blk(); blk[0] = 50;
    pulse(); model_block();
    drain(1, 100);
    if (got_q.size() > 0) chk("midrst_dc50", int'($signed(got_q[0].value)), 50);
    check_stream("midrst");

    for (int it = 0; it < 40; it++) begin
      nb = int'($urandom_range(1, 2));
      for (int b = 0; b < nb; b++) begin
        rand_block();
        pulse();
        model_block();
      end
      drain(nb, int'($urandom_range(30, 100)));
      check_stream("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
